mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have these ports, in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  EX stage has an instruction for MEM this cycle
- EXE_ready_go  in  1  EX stage output is complete
- EXEreg_bus  in  `EXEReg_BUS_LEN (74)  {mem_op[2:0], alu_result[31:0], rf_we, res_from_mem, rf_waddr[4:0], pc[31:0]}
- data_sram_rdata  in  32  load data returned by the data SRAM
- data_sram_data_ok  in  1  data_sram_rdata valid this cycle
- WB_allow_in  in  1  WB can accept an instruction
- MEM_allow_in  out  1  MEM can accept an instruction from EX
- MEM_ready_go  out  1  MEM result is complete
- MEM_valid  out  1  valid to WB
- MEMreg_bus  out  `MEMReg_BUS_LEN (103)  {alu_result, mem_result, rf_we, res_from_mem, rf_waddr, pc}
- MEM_bypass_bus  out  39  {rf_waddr, rf_we, ld_pending, rf_wdata}

Function
REQ-003 SHALL hold an internal valid bit (vld) and an EXEreg_bus copy (ebus).
- Both load at the rising edge when valid & EXE_ready_go & MEM_allow_in.
- vld SHALL clear at the rising edge when MEM_valid & WB_allow_in and no new instruction loads.
REQ-004 MEM_allow_in SHALL equal !vld | (MEM_ready_go & WB_allow_in).
REQ-005 MEM_valid SHALL equal vld & MEM_ready_go.
REQ-006 The stage SHALL run a three-state FSM:
- IDLE: vld=0.
- WAIT: load waiting for data.
- HOLD: load data captured, not yet accepted by WB.
REQ-007 FSM transitions:
- IDLE -> WAIT on entry of an instruction with res_from_mem=1.
- IDLE stays IDLE on entry of a non-load; vld=1 with no wait.
- WAIT -> HOLD on data_sram_data_ok when WB_allow_in=0.
- WAIT or HOLD -> next-entry state when WB accepts.
REQ-008 MEM_ready_go SHALL equal !res_from_mem | data_sram_data_ok | (state==HOLD).
- Load latency: combinational pass-through in the cycle data_ok arrives.
REQ-009 In WAIT, data_sram_data_ok SHALL capture data_sram_rdata into an internal 32-bit hold register.
- data_ok SHALL be ignored in IDLE and in HOLD.
REQ-010 Raw load data SHALL come from data_sram_rdata when data_ok & state==WAIT, otherwise from the hold register.
REQ-011 mem_result SHALL be extended per mem_op, with a = alu_result[1:0]:
- 000 ld.w: whole word.
- 001 ld.b: sign-extend byte a.
- 101 ld.bu: zero-extend byte a.
- 010 ld.h: sign-extend halfword a[1].
- 110 ld.hu: zero-extend halfword a[1].
- Other encodings: whole word.
REQ-012 rf_we in MEMreg_bus SHALL be ebus.rf_we & vld.
REQ-013 When WB accepts and a new instruction enters in the same edge, the new instruction SHALL replace the old one with no bubble.

Reset
REQ-014 Reset SHALL force state=IDLE, vld=0, and hold register=0.
REQ-015 Reset SHALL give MEM_valid=0, MEM_allow_in=1, and MEM_bypass_bus=0.
REQ-016 Reset asserted during WAIT SHALL discard the pending load.
- A data_ok arriving after reset and before the next load SHALL be ignored.

Configuration
REQ-017 With MEM_BYPASS_EN defined, MEM_bypass_bus SHALL be {rf_waddr, rf_we&vld, ld_pending, rf_wdata}.
- ld_pending = vld & res_from_mem & !MEM_ready_go.
- rf_wdata = res_from_mem ? mem_result : alu_result.
REQ-018 With MEM_BYPASS_EN undefined, MEM_bypass_bus SHALL be constant 0.

Verification
REQ-019 Non-load: alu_result=0x12345678, rf_waddr=5 -> next cycle MEM_valid=1, MEMreg_bus.alu_result=0x12345678.
REQ-020 ld.b at address ...3 with data_ok in the entry cycle, rdata=0x80FF_0000 -> mem_result=0xFFFFFF80, MEM_valid=1 that cycle.
REQ-021 ld.hu at address ...2, data_ok 3 cycles late, rdata=0xBEEF1234 -> MEM_ready_go=0 for 3 cycles, then mem_result=0x0000BEEF.
REQ-022 Load with data_ok while WB_allow_in=0 -> state HOLD, data held.
- MEM_allow_in=0 while WB_allow_in=0.
- Release: mem_result still correct, and a second data_ok in HOLD is ignored.
REQ-023 Reset pulse in WAIT, then data_ok -> MEM_valid stays 0, MEM_allow_in=1.
REQ-024 With MEM_BYPASS_EN defined, a pending load gives ld_pending=1; with it undefined, MEM_bypass_bus=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage between EX and WB.
//
// Latches one instruction from EX, waits for the data SRAM on loads, and
// presents the extended load result (or the ALU result) to WB. A three-state
// FSM tracks the load:
//   IDLE (no load outstanding), WAIT (waiting for data_ok), and
//   HOLD (data captured but WB not ready).
// Load data is passed through combinationally in the cycle data_ok arrives.
// Otherwise it comes from a 32-bit hold register.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   valid, EXE_ready_go EX offers a finished instruction this cycle
//   EXEreg_bus          {mem_op[2:0], alu_result[31:0], rf_we, res_from_mem,
//                        rf_waddr[4:0], pc[31:0]}
//   data_sram_rdata     load data from the data SRAM
//   data_sram_data_ok   data_sram_rdata is valid this cycle
//   WB_allow_in         WB can take an instruction
//   MEM_allow_in        this stage can take an instruction from EX
//   MEM_ready_go        this stage's result is complete
//   MEM_valid           instruction valid towards WB
//   MEMreg_bus          {alu_result, mem_result, rf_we, res_from_mem,
//                        rf_waddr, pc}
//   MEM_bypass_bus      {rf_waddr, rf_we, ld_pending, rf_wdata}
//
// Configuration macro: MEM_BYPASS_EN.
//   When it is defined, the stage drives the forwarding bus.
//   When it is undefined, MEM_bypass_bus is tied to zero.

`ifndef EXEReg_BUS_LEN
`define EXEReg_BUS_LEN 74
`endif
`ifndef MEMReg_BUS_LEN
`define MEMReg_BUS_LEN 103
`endif

module mem_stage (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic                       EXE_ready_go,
  input  logic [`EXEReg_BUS_LEN-1:0] EXEreg_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_data_ok,
  input  logic                       WB_allow_in,
  output logic                       MEM_allow_in,
  output logic                       MEM_ready_go,
  output logic                       MEM_valid,
  output logic [`MEMReg_BUS_LEN-1:0] MEMreg_bus,
  output logic [38:0]                MEM_bypass_bus
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t                     state, state_nxt;
  logic                       vld;
  logic [`EXEReg_BUS_LEN-1:0] ebus;
  logic [DATA_W-1:0]          hold_data;
  logic                       load_en, accept, capture_en, use_live;
  logic [DATA_W-1:0]          raw_data, mem_result;

  logic [2:0]        e_mem_op;
  logic [DATA_W-1:0] e_alu;
  logic              e_rf_we, e_rfm;
  logic [4:0]        e_waddr;
  logic [31:0]       e_pc;

  assign e_mem_op = ebus[73:71];
  assign e_alu    = ebus[70:39];
  assign e_rf_we  = ebus[38];
  assign e_rfm    = ebus[37];
  assign e_waddr  = ebus[36:32];
  assign e_pc     = ebus[31:0];

  // Extend the loaded word according to mem_op and the low address bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        op,
                                                    input logic [1:0]        a,
                                                    input logic [DATA_W-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b001:  load_extend = {{24{b[7]}}, b};
      3'b101:  load_extend = {24'd0, b};
      3'b010:  load_extend = {{16{h[15]}}, h};
      3'b110:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  assign load_en      = valid & EXE_ready_go & MEM_allow_in;
  assign accept       = MEM_valid & WB_allow_in;
  assign MEM_allow_in = ~vld | (MEM_ready_go & WB_allow_in);
  assign MEM_valid    = vld & MEM_ready_go;

  // Stage p0 -> p1 boundary: instruction register and valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld  <= 1'b0;
      ebus <= '0;
    end else if (load_en) begin
      vld  <= 1'b1;
      ebus <= EXEreg_bus;
    end else if (accept) begin
      vld  <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic. A new entry selects its own state, which also
  // covers the back-to-back case where WB accepts in the same edge.
  always_comb begin
    state_nxt = state;
    if (load_en)
      state_nxt = EXEreg_bus[37] ? S_WAIT : S_IDLE;
    else if (accept)
      state_nxt = S_IDLE;
    else if (state == S_WAIT && data_sram_data_ok && !WB_allow_in)
      state_nxt = S_HOLD;
  end

  // FSM outputs. data_ok is only honoured while a load is waiting.
  always_comb begin
    capture_en   = 1'b0;
    use_live     = 1'b0;
    MEM_ready_go = ~e_rfm | data_sram_data_ok | (state == S_HOLD);
    if (state == S_WAIT && data_sram_data_ok) begin
      capture_en = 1'b1;
      use_live   = 1'b1;
    end
  end

  // Load data hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           hold_data <= '0;
    else if (capture_en) hold_data <= data_sram_rdata;
  end

  assign raw_data   = use_live ? data_sram_rdata : hold_data;
  assign mem_result = load_extend(e_mem_op, e_alu[1:0], raw_data);
  assign MEMreg_bus = {e_alu, mem_result, e_rf_we & vld, e_rfm, e_waddr, e_pc};

`ifdef MEM_BYPASS_EN
  logic              ld_pending;
  logic [DATA_W-1:0] rf_wdata;
  assign ld_pending     = vld & e_rfm & ~MEM_ready_go;
  assign rf_wdata       = e_rfm ? mem_result : e_alu;
  assign MEM_bypass_bus = {e_waddr, e_rf_we & vld, ld_pending, rf_wdata};
`else
  assign MEM_bypass_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic         EXE_ready_go;
  logic [73:0]  EXEreg_bus;
  logic [31:0]  data_sram_rdata;
  logic         data_sram_data_ok;
  logic         WB_allow_in;
  logic         MEM_allow_in;
  logic         MEM_ready_go;
  logic         MEM_valid;
  logic [102:0] MEMreg_bus;
  logic [38:0]  MEM_bypass_bus;

  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .valid            (valid),
    .EXE_ready_go     (EXE_ready_go),
    .EXEreg_bus       (EXEreg_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_data_ok(data_sram_data_ok),
    .WB_allow_in      (WB_allow_in),
    .MEM_allow_in     (MEM_allow_in),
    .MEM_ready_go     (MEM_ready_go),
    .MEM_valid        (MEM_valid),
    .MEMreg_bus       (MEMreg_bus),
    .MEM_bypass_bus   (MEM_bypass_bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mr_alu, mr_res, mr_pc;
  logic        mr_we;
  logic [4:0]  mr_waddr;
  assign mr_alu   = MEMreg_bus[102:71];
  assign mr_res   = MEMreg_bus[70:39];
  assign mr_we    = MEMreg_bus[38];
  assign mr_waddr = MEMreg_bus[36:32];
  assign mr_pc    = MEMreg_bus[31:0];

  typedef struct {
    logic        is_load;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic [31:0] rdata;
    logic [31:0] exp_res;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic [31:0] alu,
                                         input logic we, input logic rfm,
                                         input logic [4:0] wa, input logic [31:0] pc);
    return {op, alu, we, rfm, wa, pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h12345678, 5'd5,  32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b1, 3'b000, 32'h00001000, 5'd1,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b001, 32'h00001003, 5'd2,  32'h80FF0000, 32'hFFFFFF80};
    vecs[3]  = '{1'b1, 3'b001, 32'h00001000, 5'd3,  32'h1234567F, 32'h0000007F};
    vecs[4]  = '{1'b1, 3'b101, 32'h00001001, 5'd4,  32'h0000A500, 32'h000000A5};
    vecs[5]  = '{1'b1, 3'b101, 32'h00001003, 5'd6,  32'h80FF0000, 32'h00000080};
    vecs[6]  = '{1'b1, 3'b010, 32'h00001000, 5'd7,  32'h00008001, 32'hFFFF8001};
    vecs[7]  = '{1'b1, 3'b010, 32'h00001002, 5'd8,  32'h7FFF0000, 32'h00007FFF};
    vecs[8]  = '{1'b1, 3'b110, 32'h00001002, 5'd9,  32'hBEEF1234, 32'h0000BEEF};
    vecs[9]  = '{1'b1, 3'b110, 32'h00001000, 5'd10, 32'hBEEF1234, 32'h00001234};
    vecs[10] = '{1'b1, 3'b011, 32'h00001001, 5'd11, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 3'b111, 32'h00001002, 5'd12, 32'h01020304, 32'h01020304};
    vecs[12] = '{1'b0, 3'b001, 32'h87654321, 5'd31, 32'h00000000, 32'h00000000};
    vecs[13] = '{1'b1, 3'b001, 32'h00001002, 5'd13, 32'h00FE0000, 32'hFFFFFFFE};
    vecs[14] = '{1'b1, 3'b101, 32'h00001002, 5'd14, 32'h00FE0000, 32'h000000FE};

    reset = 1'b1; valid = 1'b0; EXE_ready_go = 1'b1; EXEreg_bus = '0;
    data_sram_rdata = '0; data_sram_data_ok = 1'b0; WB_allow_in = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", MEM_valid, 0);
    chk("rst_allow", MEM_allow_in, 1);
    chk("rst_bypass", MEM_bypass_bus, 0);
    tick();
    reset = 1'b0;

    // Table-driven single instructions; load data arrives in the entry cycle
    for (int i = 0; i < NV; i++) begin
      logic [31:0] pc_v;
      pc_v = 32'h1C000000 + 32'(i * 4);
      EXEreg_bus = mk_bus(vecs[i].op, vecs[i].alu, 1'b1, vecs[i].is_load, vecs[i].waddr, pc_v);
      valid = 1'b1; WB_allow_in = 1'b1; data_sram_data_ok = 1'b0;
      tick();
      valid = 1'b0;
      if (vecs[i].is_load) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vecs[i].rdata;
      end
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), MEM_valid, 1);
      chk($sformatf("v%0d_alu", i), mr_alu, vecs[i].alu);
      chk($sformatf("v%0d_waddr", i), mr_waddr, vecs[i].waddr);
      chk($sformatf("v%0d_pc", i), mr_pc, pc_v);
      chk($sformatf("v%0d_we", i), mr_we, 1);
      if (vecs[i].is_load)
        chk($sformatf("v%0d_memres", i), mr_res, vecs[i].exp_res);
`ifdef MEM_BYPASS_EN
      chk($sformatf("v%0d_byp_wdata", i), MEM_bypass_bus[31:0],
          vecs[i].is_load ? vecs[i].exp_res : vecs[i].alu);
`else
      chk($sformatf("v%0d_byp_zero", i), MEM_bypass_bus, 0);
`endif
      tick();
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_drain_valid", i), MEM_valid, 0);
      chk($sformatf("v%0d_drain_we", i), mr_we, 0);
      chk($sformatf("v%0d_drain_allow", i), MEM_allow_in, 1);
    end

    // ld.hu at address ...2, data_ok three cycles late
    EXEreg_bus = mk_bus(3'b110, 32'h00002002, 1'b1, 1'b1, 5'd7, 32'h1C001000);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("late%0d_ready", c), MEM_ready_go, 0);
      chk($sformatf("late%0d_valid", c), MEM_valid, 0);
      chk($sformatf("late%0d_allow", c), MEM_allow_in, 0);
`ifdef MEM_BYPASS_EN
      chk($sformatf("late%0d_ld_pending", c), MEM_bypass_bus[32], 1);
      chk($sformatf("late%0d_byp_we", c), MEM_bypass_bus[33], 1);
`else
      chk($sformatf("late%0d_byp_zero", c), MEM_bypass_bus, 0);
`endif
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF1234;
    @(negedge clk);
    chk("late_ready", MEM_ready_go, 1);
    chk("late_valid", MEM_valid, 1);
    chk("late_memres", mr_res, 32'h0000BEEF);
`ifdef MEM_BYPASS_EN
    chk("late_ld_pending_clr", MEM_bypass_bus[32], 0);
    chk("late_byp", MEM_bypass_bus, {5'd7, 1'b1, 1'b0, 32'h0000BEEF});
`endif
    tick();
    data_sram_data_ok = 1'b0;

    // Load completes while WB stalls: HOLD, second data_ok ignored,
    // then release with a new instruction entering on the same edge
    EXEreg_bus = mk_bus(3'b000, 32'h00003000, 1'b1, 1'b1, 5'd9, 32'h1C002000);
    valid = 1'b1;
    tick();
    valid = 1'b0; WB_allow_in = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11223344;
    @(negedge clk);
    chk("hold_in_valid", MEM_valid, 1);
    chk("hold_in_allow", MEM_allow_in, 0);
    chk("hold_in_memres", mr_res, 32'h11223344);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    @(negedge clk);
    chk("hold_valid", MEM_valid, 1);
    chk("hold_allow", MEM_allow_in, 0);
    chk("hold_memres", mr_res, 32'h11223344);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55555555;
    @(negedge clk);
    chk("hold_ign_live", mr_res, 32'h11223344);
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("hold_ign_kept", mr_res, 32'h11223344);
    WB_allow_in = 1'b1; valid = 1'b1;
    EXEreg_bus = mk_bus(3'b000, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd3, 32'h1C002004);
    #1;
    chk("rel_allow", MEM_allow_in, 1);
    chk("rel_valid", MEM_valid, 1);
    chk("rel_memres", mr_res, 32'h11223344);
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", MEM_valid, 1);
    chk("b2b_ready", MEM_ready_go, 1);
    chk("b2b_alu", mr_alu, 32'hA5A5A5A5);
    chk("b2b_waddr", mr_waddr, 5'd3);
    tick();
    @(negedge clk);
    chk("b2b_drain", MEM_valid, 0);

    // Reset pulse during WAIT discards the load; later data_ok is ignored
    EXEreg_bus = mk_bus(3'b000, 32'h00004000, 1'b1, 1'b1, 5'd4, 32'h1C003000);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    #1;
    chk("rstw_wait_allow", MEM_allow_in, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("rstw_valid", MEM_valid, 0);
    chk("rstw_allow", MEM_allow_in, 1);
    reset = 1'b0;
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstw_ok_valid", MEM_valid, 0);
    chk("rstw_ok_allow", MEM_allow_in, 1);
    chk("rstw_ok_bypass", MEM_bypass_bus, 0);
    tick();
    data_sram_data_ok = 1'b0;
    EXEreg_bus = mk_bus(3'b000, 32'h00005000, 1'b1, 1'b1, 5'd6, 32'h1C004000);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk("post_rst_wait_valid", MEM_valid, 0);
    chk("post_rst_wait_ready", MEM_ready_go, 0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("post_rst_valid", MEM_valid, 1);
    chk("post_rst_memres", mr_res, 32'h0BADF00D);
    tick();
    data_sram_data_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
